reorder_buffer: RTL and testbench

- In-order retirement buffer for the out-of-order core; this is the producer side of the register file's rename tags.
- Hands out free entry tags at dispatch, collects results from the common data bus (CDB), and serves operand lookups by tag.
- Retires completed entries in program order through a commit port that drives register-file write-back and busy clearing.

---
 rtl/rob_pkg.sv | 15 +
 rtl/rob_ring_ptr.sv | 31 +++
 rtl/reorder_buffer.sv | 135 +++++++++++++
 tb/tb_reorder_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder buffer sizes, tag type and entry layout
package rob_pkg;
  localparam int ROB_DEPTH  = 64;
  localparam int ROB_TW     = $clog2(ROB_DEPTH);
  localparam int ROB_DATA_W = 32;

  typedef logic [ROB_TW-1:0] rob_tag_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [5:0]            rd;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;
endpackage

// File: rtl/rob_ring_ptr.sv
// rtl/rob_ring_ptr.sv - TW-bit wrapping pointer with increment enable and synchronous clear
module rob_ring_ptr #(
  parameter int TW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [TW-1:0] ptr
);
  logic [TW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer; ROB_CDB_BYPASS_EN adds same-cycle CDB-to-lookup bypass
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int DATA_W = ROB_DATA_W,
  localparam int TW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [5:0]        alloc_rd,
  output logic              alloc_ready,
  output logic [TW-1:0]     alloc_tag,
  input  logic              cdb_valid,
  input  logic [TW-1:0]     cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TW-1:0]     rd_tag1,
  input  logic [TW-1:0]     rd_tag2,
  output logic [DATA_W:0]   rd_data1,
  output logic [DATA_W:0]   rd_data2,
  input  logic              flush,
  output logic              commit_valid,
  output logic [5:0]        commit_rd,
  output logic [TW-1:0]     commit_tag,
  output logic [DATA_W-1:0] commit_data,
  output logic [TW:0]       count
);
  localparam logic [TW:0] FULL_CNT = (TW+1)'(DEPTH);

  rob_entry_t        entries_q [DEPTH];
  rob_entry_t        entries_d [DEPTH];
  logic [TW:0]       count_q, count_d;
  logic              commit_valid_q, commit_valid_d;
  logic [5:0]        commit_rd_q, commit_rd_d;
  logic [TW-1:0]     commit_tag_q, commit_tag_d;
  logic [DATA_W-1:0] commit_data_q, commit_data_d;
  logic [TW-1:0]     head, tail;
  logic              alloc_fire, commit_fire;

  assign alloc_ready = (count_q != FULL_CNT);
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = entries_q[head].valid && entries_q[head].done;

  rob_ring_ptr #(.TW(TW)) u_head (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (commit_fire && !flush),
    .ptr   (head)
  );

  rob_ring_ptr #(.TW(TW)) u_tail (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (alloc_fire && !flush),
    .ptr   (tail)
  );

  always_comb begin
    entries_d      = entries_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_tag_d   = commit_tag_q;
    commit_data_d  = commit_data_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
      count_d = '0;
    end else begin
      if (cdb_valid && entries_q[cdb_tag].valid) begin
        entries_d[cdb_tag].done = 1'b1;
        entries_d[cdb_tag].data = cdb_data;
      end
      // A full buffer never allocates, so the tail slot is always free here.
      if (alloc_fire) begin
        entries_d[tail].valid = 1'b1;
        entries_d[tail].done  = 1'b0;
        entries_d[tail].rd    = alloc_rd;
      end
      if (commit_fire) begin
        entries_d[head].valid = 1'b0;
        commit_valid_d        = 1'b1;
        commit_rd_d           = entries_q[head].rd;
        commit_tag_d          = head;
        commit_data_d         = entries_q[head].data;
      end
      count_d = count_q + (TW+1)'(alloc_fire) - (TW+1)'(commit_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_tag_q   <= '0;
      commit_data_q  <= '0;
    end else begin
      entries_q      <= entries_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_tag_q   <= commit_tag_d;
      commit_data_q  <= commit_data_d;
    end
  end

  always_comb begin
    rd_data1 = {entries_q[rd_tag1].valid && entries_q[rd_tag1].done, entries_q[rd_tag1].data};
    rd_data2 = {entries_q[rd_tag2].valid && entries_q[rd_tag2].done, entries_q[rd_tag2].data};
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && (cdb_tag == rd_tag1) && entries_q[rd_tag1].valid) begin
      rd_data1 = {1'b1, cdb_data};
    end
    if (cdb_valid && (cdb_tag == rd_tag2) && entries_q[rd_tag2].valid) begin
      rd_data2 = {1'b1, cdb_data};
    end
`endif
  end

  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_tag   = commit_tag_q;
  assign commit_data  = commit_data_q;
  assign count        = count_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed vector bench for reorder_buffer
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic [5:0]  alloc_rd;
  logic        alloc_ready;
  logic [5:0]  alloc_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [5:0]  rd_tag1, rd_tag2;
  logic [32:0] rd_data1, rd_data2;
  logic        flush;
  logic        commit_valid;
  logic [5:0]  commit_rd;
  logic [5:0]  commit_tag;
  logic [31:0] commit_data;
  logic [6:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rd_tag1(rd_tag1), .rd_tag2(rd_tag2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .flush(flush),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data), .count(count)
  );

  typedef struct {
    logic        av;
    logic [5:0]  ard;
    logic        cv;
    logic [5:0]  ctag;
    logic [31:0] cdata;
    logic [5:0]  rt1;
    logic        e_ready;
    logic [5:0]  e_tag;
    logic [6:0]  e_count;
    logic        e_cv;
    logic [5:0]  e_crd;
    logic [5:0]  e_ctag;
    logic [31:0] e_cdata;
    logic [1:0]  rmode;   // 0: skip lookup, 1: done bit only, 2: done and data
    logic [32:0] e_rd1;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic av, logic [5:0] ard, logic cv, logic [5:0] ctag,
                              logic [31:0] cdata, logic [5:0] rt1, logic er, logic [5:0] et,
                              logic [6:0] ec, logic ecv, logic [5:0] ecrd, logic [5:0] ectag,
                              logic [31:0] ecd, logic [1:0] rm, logic [32:0] erd);
    vec_t v;
    v.av = av; v.ard = ard; v.cv = cv; v.ctag = ctag; v.cdata = cdata; v.rt1 = rt1;
    v.e_ready = er; v.e_tag = et; v.e_count = ec; v.e_cv = ecv; v.e_crd = ecrd;
    v.e_ctag = ectag; v.e_cdata = ecd; v.rmode = rm; v.e_rd1 = erd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_rd = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    rd_tag1 = '0; rd_tag2 = '0; flush = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0,            0, 1, 0, 0, 0, 0, 0, 0,            2, 33'h0);
    vecs[1]  = mk(1, 5, 0, 0, 0,            0, 1, 0, 0, 0, 0, 0, 0,            0, 33'h0);
    vecs[2]  = mk(1, 6, 0, 0, 0,            0, 1, 1, 1, 0, 0, 0, 0,            0, 33'h0);
    vecs[3]  = mk(1, 7, 0, 0, 0,            0, 1, 2, 2, 0, 0, 0, 0,            0, 33'h0);
    vecs[4]  = mk(0, 0, 0, 0, 0,            1, 1, 3, 3, 0, 0, 0, 0,            1, 33'h0);
    vecs[5]  = mk(0, 0, 1, 1, 32'hAA,       1, 1, 3, 3, 0, 0, 0, 0,            0, 33'h0);
    vecs[6]  = mk(0, 0, 1, 0, 32'h55,       1, 1, 3, 3, 0, 0, 0, 0,            2, {1'b1, 32'hAA});
    vecs[7]  = mk(0, 0, 0, 0, 0,            0, 1, 3, 3, 0, 0, 0, 0,            2, {1'b1, 32'h55});
    vecs[8]  = mk(0, 0, 0, 0, 0,            0, 1, 3, 2, 1, 5, 0, 32'h55,       0, 33'h0);
    vecs[9]  = mk(0, 0, 0, 0, 0,            0, 1, 3, 1, 1, 6, 1, 32'hAA,       0, 33'h0);
    vecs[10] = mk(0, 0, 1, 2, 32'h77,       0, 1, 3, 1, 0, 0, 0, 0,            0, 33'h0);
    vecs[11] = mk(0, 0, 0, 0, 0,            2, 1, 3, 1, 0, 0, 0, 0,            2, {1'b1, 32'h77});
    vecs[12] = mk(0, 0, 0, 0, 0,            0, 1, 3, 0, 1, 7, 2, 32'h77,       0, 33'h0);
    vecs[13] = mk(0, 0, 0, 0, 0,            0, 1, 3, 0, 0, 0, 0, 0,            0, 33'h0);

    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    check("reset_commit_rd", 33'(commit_rd), 33'h0);
    check("reset_commit_tag", 33'(commit_tag), 33'h0);
    check("reset_commit_data", 33'(commit_data), 33'h0);
    check("reset_rd_data2", rd_data2, 33'h0);

    for (int i = 0; i < 14; i++) begin
      alloc_valid = vecs[i].av; alloc_rd = vecs[i].ard;
      cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ctag; cdb_data = vecs[i].cdata;
      rd_tag1 = vecs[i].rt1;
      #1;
      check($sformatf("v%0d_alloc_ready", i), 33'(alloc_ready), 33'(vecs[i].e_ready));
      check($sformatf("v%0d_alloc_tag", i), 33'(alloc_tag), 33'(vecs[i].e_tag));
      check($sformatf("v%0d_count", i), 33'(count), 33'(vecs[i].e_count));
      check($sformatf("v%0d_commit_valid", i), 33'(commit_valid), 33'(vecs[i].e_cv));
      if (vecs[i].e_cv) begin
        check($sformatf("v%0d_commit_rd", i), 33'(commit_rd), 33'(vecs[i].e_crd));
        check($sformatf("v%0d_commit_tag", i), 33'(commit_tag), 33'(vecs[i].e_ctag));
        check($sformatf("v%0d_commit_data", i), 33'(commit_data), 33'(vecs[i].e_cdata));
      end
      if (vecs[i].rmode == 2'd1)
        check($sformatf("v%0d_rd1_done", i), 33'(rd_data1[32]), 33'(vecs[i].e_rd1[32]));
      else if (vecs[i].rmode == 2'd2)
        check($sformatf("v%0d_rd_data1", i), rd_data1, vecs[i].e_rd1);
      step();
    end
    idle();

    // CDB-to-lookup visibility on tag 3
    alloc_valid = 1'b1; alloc_rd = 6'd9;
    #1 check("byp_alloc_tag", 33'(alloc_tag), 33'd3);
    step();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h1234; rd_tag2 = 6'd3;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    check("byp_same_cycle", rd_data2, {1'b1, 32'h1234});
`else
    check("nobyp_same_cycle_done", 33'(rd_data2[32]), 33'h0);
`endif
    step();
    cdb_valid = 1'b0;
    #1 check("byp_next_cycle", rd_data2, {1'b1, 32'h1234});
    step();
    #1;
    check("byp_commit_valid", 33'(commit_valid), 33'h1);
    check("byp_commit_tag", 33'(commit_tag), 33'd3);
    check("byp_commit_data", 33'(commit_data), 33'h1234);
    check("byp_count", 33'(count), 33'h0);

    // flush beats a pending commit and a same-cycle CDB write
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_rd = 6'(10 + i);
      step();
    end
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'h99;
    #1 check("fl_count_before", 33'(count), 33'd5);
    step();
    flush = 1'b1; cdb_tag = 6'd5; cdb_data = 32'h42;
    step();
    flush = 1'b0; cdb_valid = 1'b0; rd_tag1 = 6'd4; rd_tag2 = 6'd5;
    #1;
    check("fl_count", 33'(count), 33'h0);
    check("fl_commit_valid", 33'(commit_valid), 33'h0);
    check("fl_alloc_tag", 33'(alloc_tag), 33'h0);
    check("fl_alloc_ready", 33'(alloc_ready), 33'h1);
    check("fl_rd1_done", 33'(rd_data1[32]), 33'h0);
    check("fl_rd2_done", 33'(rd_data2[32]), 33'h0);
    step();
    #1 check("fl_commit_valid_next", 33'(commit_valid), 33'h0);
    idle();

    // fill to DEPTH, then a held request waits for the freed slot
    for (int i = 0; i < 64; i++) begin
      alloc_valid = 1'b1; alloc_rd = 6'(i);
      #1;
      check($sformatf("fill_tag_%0d", i), 33'(alloc_tag), 33'(i));
      if (i == 63) check("fill_ready_last", 33'(alloc_ready), 33'h1);
      step();
    end
    alloc_rd = 6'd33;
    cdb_valid = 1'b1; cdb_tag = 6'd0; cdb_data = 32'hC0;
    #1;
    check("full_ready", 33'(alloc_ready), 33'h0);
    check("full_count", 33'(count), 33'd64);
    step();
    cdb_valid = 1'b0;
    #1 check("full_ready_commit_cycle", 33'(alloc_ready), 33'h0);
    step();
    #1;
    check("full_ready_after", 33'(alloc_ready), 33'h1);
    check("full_wrap_tag", 33'(alloc_tag), 33'h0);
    check("full_commit_valid", 33'(commit_valid), 33'h1);
    check("full_commit_tag", 33'(commit_tag), 33'h0);
    check("full_commit_data", 33'(commit_data), 33'hC0);
    check("full_count_63", 33'(count), 33'd63);
    step();
    alloc_valid = 1'b0;
    #1;
    check("refill_count", 33'(count), 33'd64);
    check("refill_tag", 33'(alloc_tag), 33'd1);
    check("refill_ready", 33'(alloc_ready), 33'h0);

    // same-cycle alloc and commit at count 10
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      alloc_valid = 1'b1; alloc_rd = 6'(40 + i);
      step();
    end
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 6'd0; cdb_data = 32'hD0;
    step();
    cdb_valid = 1'b0; alloc_valid = 1'b1; alloc_rd = 6'd20;
    #1;
    check("both_count_before", 33'(count), 33'd10);
    check("both_tag_before", 33'(alloc_tag), 33'd10);
    step();
    alloc_valid = 1'b0;
    #1;
    check("both_count_after", 33'(count), 33'd10);
    check("both_tag_after", 33'(alloc_tag), 33'd11);
    check("both_commit_valid", 33'(commit_valid), 33'h1);
    check("both_commit_tag", 33'(commit_tag), 33'h0);
    check("both_commit_rd", 33'(commit_rd), 33'd40);
    cdb_valid = 1'b1; cdb_tag = 6'd1; cdb_data = 32'hD1;
    step();
    cdb_valid = 1'b0;
    step();
    #1;
    check("head_next_valid", 33'(commit_valid), 33'h1);
    check("head_next_tag", 33'(commit_tag), 33'd1);
    check("head_next_data", 33'(commit_data), 33'hD1);
    check("head_next_count", 33'(count), 33'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
